count_cmd_sequencer: RTL and testbench

- Upstream feeder for the 3-bit load/count-down counter.
- Accepts count targets over a valid/ready command interface and buffers them in a small FIFO.
- Issues one target at a time to the counter: one-cycle load, then count enable until the counter reports done.
- Reports per-run completion, a completed-run tally, FIFO level, and a sticky timeout error for a stalled counter.

---
 rtl/count_cmd_sequencer_if.sv | 22 ++
 rtl/count_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_count_cmd_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_cmd_sequencer_if.sv
// Command handshake bundle between a producer of count targets and the sequencer.
// The producer drives valid/value; the sequencer answers with ready.
`timescale 1ns/1ps
interface count_cmd_sequencer_if #(
  parameter int W = 3
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_value;

  modport master (
    output cmd_valid,
    output cmd_value,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_value,
    output cmd_ready
  );
endinterface

// File: rtl/count_cmd_sequencer.sv
// Buffers count targets in a small FIFO and drives them one at a time into a
// load/count-down counter: load, settle, then count until done or timeout.
`timescale 1ns/1ps
module count_cmd_sequencer #(
  parameter int W       = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int TALLY_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  count_cmd_sequencer_if.slave     cmd,
  input  logic                     flush,
  output logic [W-1:0]             cnt_count_to,
  output logic                     cnt_load,
  output logic                     cnt_count_en,
  input  logic                     cnt_done,
  output logic                     busy,
  output logic                     run_done,
  output logic [TALLY_W-1:0]       tally,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         target_q, target_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [TALLY_W-1:0]   tally_q, tally_d;
  logic                 run_done_q, run_done_d;
  logic                 err_q, err_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [W-1:0]         mem_q [DEPTH];

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [W-1:0]         head;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign fifo_full     = (level_q == LW'(DEPTH));
  assign fifo_empty    = (level_q == '0);
  assign cmd.cmd_ready = !fifo_full;
  assign push          = cmd.cmd_valid && !fifo_full && !flush;
  assign head          = mem_q[rd_ptr_q];

  // Sequencing FSM: next state, target capture, timeout and tally.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    timer_d    = timer_q;
    tally_d    = tally_q;
    err_d      = err_q;
    run_done_d = 1'b0;
    pop        = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head != '0) begin
              target_d = head;
              state_d  = S_LOAD;
            end else begin
              // A zero target is already "counted out": report it without touching the counter.
              run_done_d = 1'b1;
              tally_d    = tally_q + 1'b1;
            end
          end
        end
        S_LOAD: begin
          timer_d = '0;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          // cnt_done is ignored here so a level left over from the previous run cannot end this one.
          state_d = S_RUN;
        end
        S_RUN: begin
          if (cnt_done) begin
            state_d    = S_IDLE;
            run_done_d = 1'b1;
            tally_d    = tally_q + 1'b1;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      timer_q    <= '0;
      tally_q    <= '0;
      run_done_q <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      timer_q    <= timer_d;
      tally_q    <= tally_d;
      run_done_q <= run_done_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read once the level says it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd.cmd_value;
  end

  assign cnt_count_to = target_q;
  assign cnt_load     = (state_q == S_LOAD);
  assign cnt_count_en = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign run_done     = run_done_q;
  assign tally        = tally_q;
  assign fifo_level   = level_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_count_cmd_sequencer.sv
// Randomised and directed bench for count_cmd_sequencer, checked every cycle
// against a queue-based model of the sequencing rules.
`timescale 1ns/1ps
module tb_count_cmd_sequencer;
  localparam int W       = 3;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int TALLY_W = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               flush = 1'b0;
  logic               cnt_done;
  logic [W-1:0]       cnt_count_to;
  logic               cnt_load, cnt_count_en, busy, run_done, timeout_err;
  logic [TALLY_W-1:0] tally;
  logic [LW-1:0]      fifo_level;

  count_cmd_sequencer_if #(.W(W)) cmd_if ();

  count_cmd_sequencer #(
    .W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TALLY_W(TALLY_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd_if), .flush(flush),
    .cnt_count_to(cnt_count_to), .cnt_load(cnt_load), .cnt_count_en(cnt_count_en),
    .cnt_done(cnt_done), .busy(busy), .run_done(run_done), .tally(tally),
    .fifo_level(fifo_level), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Counter stand-in: 0 = real load/count-down, 1 = done tied low,
  // 2 = done high whenever not counting, 3 = random done.
  int         mode = 0;
  logic       rnd_done = 1'b0;
  logic [W-1:0] ctr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ctr <= '0;
    else if (cnt_load) ctr <= cnt_count_to;
    else if (cnt_count_en && ctr != '0) ctr <= ctr - 1'b1;
  end

  always_comb begin
    cnt_done = 1'b0;
    case (mode)
      0:       cnt_done = (ctr == '0);
      1:       cnt_done = 1'b0;
      2:       cnt_done = !cnt_count_en || (ctr == '0);
      default: cnt_done = rnd_done;
    endcase
  end

  // Behavioural model: pending targets in a queue, the active run tracked by its age in cycles.
  int mq[$];
  bit m_active = 0;
  int m_age    = 0;
  int m_target = 0;
  int m_tally  = 0;
  bit m_err    = 0;
  bit m_rdone  = 0;

  bit s_valid = 0, s_flush = 0, s_done = 0;
  int s_value = 0;

  task automatic m_reset();
    mq.delete();
    m_active = 0; m_age = 0; m_target = 0;
    m_tally = 0; m_err = 0; m_rdone = 0;
  endtask

  task automatic m_step();
    bit acc;
    int v;
    acc = s_valid && (mq.size() < DEPTH);
    if (s_flush) begin
      mq.delete();
      m_active = 0;
      m_rdone  = 0;
      return;
    end
    m_rdone = 0;
    if (!m_active) begin
      if (mq.size() > 0) begin
        v = mq.pop_front();
        if (v != 0) begin
          m_active = 1; m_age = 0; m_target = v;
        end else begin
          m_rdone = 1;
          m_tally = (m_tally + 1) % (1 << TALLY_W);
        end
      end
    end else if (m_age < 2) begin
      m_age++;
    end else if (s_done) begin
      m_active = 0;
      m_rdone  = 1;
      m_tally  = (m_tally + 1) % (1 << TALLY_W);
    end else if (m_age - 1 == TIMEOUT) begin
      m_active = 0;
      m_err    = 1;
    end else begin
      m_age++;
    end
    if (acc) mq.push_back(s_value);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  int loads[$];
  int n_rdone = 0;

  // Compare DUT against model mid-cycle and snapshot the inputs the next edge will see.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cmd_ready",    int'(cmd_if.cmd_ready), int'(mq.size() < DEPTH));
      chk("fifo_level",   int'(fifo_level),       mq.size());
      chk("busy",         int'(busy),             int'(m_active));
      chk("cnt_load",     int'(cnt_load),         int'(m_active && m_age == 0));
      chk("cnt_count_en", int'(cnt_count_en),     int'(m_active && m_age >= 2));
      chk("cnt_count_to", int'(cnt_count_to),     m_target);
      chk("run_done",     int'(run_done),         int'(m_rdone));
      chk("tally",        int'(tally),            m_tally);
      chk("timeout_err",  int'(timeout_err),      int'(m_err));
      if (cnt_load) loads.push_back(int'(cnt_count_to));
      if (run_done) n_rdone++;
    end
    s_valid = cmd_if.cmd_valid;
    s_value = int'(cmd_if.cmd_value);
    s_flush = flush;
    s_done  = cnt_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(int v, string nm);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_value = W'(v);
    chk(nm, int'(cmd_if.cmd_ready), 1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget, output int en_cyc);
    int n;
    n = 0;
    en_cyc = 0;
    while (n < budget) begin
      @(negedge clk);
      if (cnt_count_en) en_cyc++;
      if (!busy && fifo_level == '0) break;
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_errors++;
      $display("FAIL wait_idle: still busy after %0d cycles (busy=%0d level=%0d)", budget, busy, fifo_level);
    end
    tick();
  endtask

  task automatic wait_run(int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (cnt_count_en) break;
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_errors++;
      $display("FAIL wait_run: count enable never rose within %0d cycles", budget);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"},   int'(cmd_if.cmd_ready), 1);
    chk({tag, "_level"},   int'(fifo_level), 0);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_load"},    int'(cnt_load), 0);
    chk({tag, "_en"},      int'(cnt_count_en), 0);
    chk({tag, "_to"},      int'(cnt_count_to), 0);
    chk({tag, "_rdone"},   int'(run_done), 0);
    chk({tag, "_tally"},   int'(tally), 0);
    chk({tag, "_err"},     int'(timeout_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, r0, en, peak, ready_seen;
    int exp1[4];
    exp1 = '{7, 3, 5, 1};
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_value = '0;

    // Reset
    repeat (3) tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Four back-to-back commands through a real counter
    mode = 0;
    base = loads.size();
    r0   = n_rdone;
    peak = 0;
    foreach (exp1[i]) begin
      push_chk(exp1[i], "b2b_ready");
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    wait_idle(200, en);
    chk("b2b_level_peak_ge3", int'(peak >= 3), 1);
    chk("b2b_load_count", loads.size() - base, 4);
    foreach (exp1[i]) if (base + i < loads.size()) chk("b2b_load_value", loads[base + i], exp1[i]);
    chk("b2b_rdone_pulses", n_rdone - r0, 4);
    chk("b2b_tally", int'(tally), 4);
    chk("b2b_busy", int'(busy), 0);
    chk("b2b_err", int'(timeout_err), 0);

    // Fill the FIFO while the counter is held off
    mode = 1;
    for (int v = 2; v <= 6; v++) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_value = W'(v);
      tick();
    end
    cmd_if.cmd_value = W'(1);
    chk("full_ready", int'(cmd_if.cmd_ready), 0);
    chk("full_level", int'(fifo_level), 4);
    tick();
    tick();
    chk("full_5th_rejected", int'(fifo_level), 4);
    mode = 0;
    ready_seen = 0;
    for (int n = 0; n < 40 && ready_seen == 0; n++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) ready_seen = 1;
    end
    if (ready_seen == 0) begin
      n_checks++; n_errors++;
      $display("FAIL full_ready_return: cmd_ready stayed 0 for 40 cycles");
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    chk("full_5th_landed", int'(fifo_level), 4);
    wait_idle(300, en);
    chk("full_tally", int'(tally), 10);

    // Zero target is skipped without a load
    t0   = int'(tally);
    base = loads.size();
    r0   = n_rdone;
    push_chk(0, "zero_ready");
    push_chk(2, "zero_ready2");
    wait_idle(100, en);
    chk("zero_load_count", loads.size() - base, 1);
    if (loads.size() > base) chk("zero_load_value", loads[base], 2);
    chk("zero_rdone_pulses", n_rdone - r0, 2);
    chk("zero_tally", int'(tally), (t0 + 2) % 256);

    // Stale done held high through LOAD/SETTLE
    mode = 2;
    t0   = int'(tally);
    push_chk(6, "stale_ready");
    wait_idle(100, en);
    chk("stale_run_cycles", en, 7);
    chk("stale_tally", int'(tally), (t0 + 1) % 256);
    chk("stale_err", int'(timeout_err), 0);

    // Timeout on a stalled counter
    mode = 1;
    t0   = int'(tally);
    push_chk(4, "to_ready");
    wait_idle(100, en);
    chk("to_run_cycles", en, TIMEOUT);
    chk("to_err", int'(timeout_err), 1);
    chk("to_tally", int'(tally), t0);
    chk("to_en", int'(cnt_count_en), 0);
    chk("to_busy", int'(busy), 0);
    mode = 0;
    push_chk(2, "to_next_ready");
    wait_idle(100, en);
    chk("to_next_tally", int'(tally), (t0 + 1) % 256);
    chk("to_err_sticky", int'(timeout_err), 1);

    // Random traffic with random done and occasional flush
    mode = 3;
    for (int i = 0; i < 3000; i++) begin
      cmd_if.cmd_valid = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      cmd_if.cmd_value = W'($urandom_range(0, 7));
      flush            = ($urandom_range(0, 99) == 0);
      rnd_done         = ($urandom_range(0, 5) == 0);
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    flush            = 1'b0;
    mode             = 0;
    wait_idle(300, en);

    // Flush during a run
    mode = 1;
    push_chk(7, "fl_ready");
    push_chk(3, "fl_ready");
    push_chk(5, "fl_ready");
    wait_run(50);
    @(posedge clk);
    #1;
    t0 = int'(tally);
    flush            = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_value = W'(3);
    tick();
    flush            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    chk("flush_level", int'(fifo_level), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_en", int'(cnt_count_en), 0);
    chk("flush_rdone", int'(run_done), 0);
    chk("flush_tally", int'(tally), t0);
    chk("flush_err_kept", int'(timeout_err), 1);

    // Asynchronous reset in the middle of a run
    push_chk(5, "rst_ready");
    push_chk(6, "rst_ready");
    wait_run(50);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    tick();
    reset_n = 1'b1;
    mode = 0;
    tick();
    tick();
    chk("post_rst_level", int'(fifo_level), 0);
    chk("post_rst_tally", int'(tally), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
